// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer; drives edge/bit counters, checker enables,
// deserializer strobe and end-of-frame status pulses.
module uart_rx_ctrl #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      Strt_Glitch,
  input  logic                      Par_Err,
  input  logic                      Stp_Err,
  output logic [PRESCALE_WIDTH-1:0] Edge_Cnt,
  output logic [3:0]                Bit_Cnt,
  output logic                      Dat_Samp_En,
  output logic                      Strt_Chk_En,
  output logic                      Par_Chk_En,
  output logic                      Stp_Chk_En,
  output logic                      Deser_En,
  output logic                      Busy,
  output logic                      Data_Valid,
  output logic                      Frame_Err,
  output logic                      Parity_Err
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                    r_state;
  logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
  logic [3:0]                r_bit_cnt;
  logic                      r_par_en;
  logic                      r_par_flag;
  logic                      r_deser_en;
  logic                      r_data_valid;
  logic                      r_frame_err;
  logic                      r_parity_err;
  logic                      w_eob;
  logic                      w_sp;
  assign w_eob = r_edge_cnt == Prescale - PRESCALE_WIDTH'(1);
  assign w_sp  = r_edge_cnt == (Prescale >> 1) + PRESCALE_WIDTH'(2);
  // Deser_En is registered one cycle after the sample point, so it lands on SP+1
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= IDLE;
      r_edge_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_par_en     <= 1'b0;
      r_par_flag   <= 1'b0;
      r_deser_en   <= 1'b0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_deser_en   <= (r_state == DATA) && w_sp;
      r_edge_cnt   <= (r_state == IDLE || w_eob) ? '0 : r_edge_cnt + PRESCALE_WIDTH'(1);
      case (r_state)
        IDLE: if (!RX_IN) begin
          r_state  <= START;
          r_par_en <= PAR_EN;
        end
        START: if (w_eob) begin
          r_state   <= Strt_Glitch ? IDLE : DATA;
          r_bit_cnt <= '0;
        end
        DATA: if (w_eob) begin
          if (r_bit_cnt == 4'd7) r_state <= r_par_en ? PARITY : STOP;
          else r_bit_cnt <= r_bit_cnt + 4'd1;
        end
        PARITY: if (w_eob) begin
          r_par_flag <= Par_Err;
          r_state    <= STOP;
        end
        STOP: if (w_eob) begin
          r_frame_err  <= Stp_Err;
          r_parity_err <= r_par_flag;
          r_data_valid <= !Stp_Err && !r_par_flag;
          r_par_flag   <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign Edge_Cnt    = r_edge_cnt;
  assign Bit_Cnt     = r_bit_cnt;
  assign Busy        = r_state != IDLE;
  assign Dat_Samp_En = Busy;
  assign Strt_Chk_En = r_state == START;
  assign Par_Chk_En  = r_state == PARITY;
  assign Stp_Chk_En  = r_state == STOP;
  assign Deser_En    = r_deser_en;
  assign Data_Valid  = r_data_valid;
  assign Frame_Err   = r_frame_err;
  assign Parity_Err  = r_parity_err;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed checks of frame timing, enables, pulses, glitch and reset behaviour.
module tb_uart_rx_ctrl;
  localparam int PW = 6;
  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic [PW-1:0] Prescale = PW'(8);
  logic          Strt_Glitch = 1'b0;
  logic          Par_Err = 1'b0;
  logic          Stp_Err = 1'b0;
  logic [PW-1:0] Edge_Cnt;
  logic [3:0]    Bit_Cnt;
  logic          Dat_Samp_En, Strt_Chk_En, Par_Chk_En, Stp_Chk_En, Deser_En, Busy;
  logic          Data_Valid, Frame_Err, Parity_Err;
  int            checks = 0;
  int            errors = 0;

  uart_rx_ctrl #(.PRESCALE_WIDTH(PW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
    .Strt_Glitch(Strt_Glitch), .Par_Err(Par_Err), .Stp_Err(Stp_Err),
    .Edge_Cnt(Edge_Cnt), .Bit_Cnt(Bit_Cnt), .Dat_Samp_En(Dat_Samp_En),
    .Strt_Chk_En(Strt_Chk_En), .Par_Chk_En(Par_Chk_En), .Stp_Chk_En(Stp_Chk_En),
    .Deser_En(Deser_En), .Busy(Busy), .Data_Valid(Data_Valid),
    .Frame_Err(Frame_Err), .Parity_Err(Parity_Err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " outputs"}, {23'd0, Busy, Dat_Samp_En, Strt_Chk_En, Par_Chk_En, Stp_Chk_En,
        Deser_En, Data_Valid, Frame_Err, Parity_Err}, 32'd0);
    chk({tag, " edge"}, 32'(Edge_Cnt), 32'd0);
  endtask

  // Runs one frame starting in the current (idle) cycle 0; expectations come from frame arithmetic.
  task automatic do_frame(input int p, input bit pe, input logic [7:0] d, input bit perr, input bit serr);
    int sp, total, b, e;
    bit busy, last;
    logic [10:0] bits;
    string t;
    sp = p / 2 + 2;
    total = (10 + (pe ? 1 : 0)) * p;
    bits = pe ? {1'b1, ^d, d, 1'b0} : {2'b11, d, 1'b0};
    chk($sformatf("p%0d c0 busy", p), 32'(Busy), 32'd0);
    Prescale = PW'(p);
    PAR_EN = pe;
    RX_IN = 1'b0;
    Strt_Glitch = 1'b0;
    Par_Err = 1'b0;
    Stp_Err = 1'b0;
    for (int n = 1; n <= total + 1; n++) begin
      tick();
      b = (n - 1) / p;
      e = (n - 1) % p;
      busy = n <= total;
      last = n == total + 1;
      t = $sformatf("p%0d pe%0d c%0d", p, pe, n);
      chk({t, " busy"}, 32'(Busy), 32'(busy));
      chk({t, " samp_en"}, 32'(Dat_Samp_En), 32'(busy));
      chk({t, " edge"}, 32'(Edge_Cnt), busy ? 32'(e) : 32'd0);
      chk({t, " chk_en"}, {29'd0, Strt_Chk_En, Par_Chk_En, Stp_Chk_En},
          {29'd0, busy && b == 0, busy && pe && b == 9, busy && b == 9 + (pe ? 1 : 0)});
      if (busy && b >= 1 && b <= 8) chk({t, " bit_cnt"}, 32'(Bit_Cnt), 32'(b - 1));
      chk({t, " deser"}, 32'(Deser_En), 32'(busy && b >= 1 && b <= 8 && e == sp + 1));
      chk({t, " data_valid"}, 32'(Data_Valid), 32'(last && !serr && !(pe && perr)));
      chk({t, " frame_err"}, 32'(Frame_Err), 32'(last && serr));
      chk({t, " parity_err"}, 32'(Parity_Err), 32'(last && pe && perr));
      RX_IN = busy ? bits[b] : 1'b1;
      Par_Err = busy && pe && b == 9 && e >= sp + 1 && perr;
      Stp_Err = busy && b == 9 + (pe ? 1 : 0) && e >= sp + 1 && serr;
      PAR_EN = busy ? !pe : pe;
    end
  endtask

  initial begin
    #2 RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      RX_IN = i[0];
      tick();
      chk_idle($sformatf("reset c%0d", i));
      chk($sformatf("reset c%0d bit_cnt", i), 32'(Bit_Cnt), 32'd0);
    end
    RX_IN = 1'b1;
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle($sformatf("post-reset idle c%0d", i));
    end
    do_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0);
    do_frame(16, 1'b1, 8'h3C, 1'b1, 1'b0);
    do_frame(16, 1'b1, 8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle($sformatf("gap c%0d", i));
    end
    do_frame(8, 1'b0, 8'h5A, 1'b0, 1'b1);
    tick();
    chk_idle("pre-glitch");
    Prescale = PW'(8);
    RX_IN = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      chk($sformatf("glitch c%0d busy", n), 32'(Busy), 32'(n <= 8));
      chk($sformatf("glitch c%0d strt_en", n), 32'(Strt_Chk_En), 32'(n <= 8));
      chk($sformatf("glitch c%0d deser/pulses", n), {28'd0, Deser_En, Data_Valid, Frame_Err, Parity_Err}, 32'd0);
      RX_IN = n >= 2;
      Strt_Glitch = n == 8;
    end
    chk_idle("glitch end");
    RX_IN = 1'b0;
    for (int n = 1; n <= 44; n++) begin
      tick();
      RX_IN = n >= 2;
    end
    chk("mid-data busy", 32'(Busy), 32'd1);
    chk("mid-data bit_cnt", 32'(Bit_Cnt), 32'd4);
    RST = 1'b0;
    #1;
    chk_idle("async reset");
    chk("async reset bit_cnt", 32'(Bit_Cnt), 32'd0);
    tick();
    chk_idle("reset held");
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("after reset c%0d", i));
    end
    do_frame(32, 1'b0, 8'hC3, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
